// File: rtl/int_conv_pkg.sv
// -----------------------------------------------------------------------------
// int_conv_pkg
//   Types and codebook constants shared by the 16->8 activation compressor and
//   the 8->16 expander (int8to16_stream).
//   The piecewise-log codebook has seven shift-add segments (s0..s6). Codes 254
//   and 255 map to explicit full-scale constants.
// -----------------------------------------------------------------------------
package int_conv_pkg;

    typedef logic [7:0]  code8_t;
    typedef logic [15:0] val16_t;

    localparam int LOG_SEGS = 8;

    // First code of each segment. Entry 7 covers the two constant codes.
    localparam code8_t LOG_CODE_BASE [LOG_SEGS] = '{
        8'd0, 8'd128, 8'd192, 8'd224, 8'd240, 8'd248, 8'd252, 8'd254
    };

    // Output value of the first code in each segment.
    localparam val16_t LOG_VAL_BASE [LOG_SEGS] = '{
        16'd0, 16'd128, 16'd256, 16'd512, 16'd1024, 16'd2048, 16'd4096, 16'h8000
    };

    // Step size between codes in a segment, as a left shift.
    localparam logic [3:0] LOG_SHIFT [LOG_SEGS] = '{
        4'd0, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd0
    };

    localparam val16_t LOG_FULL_SCALE = 16'hFFFF;
    localparam val16_t LOG_C254_VAL   = 16'h8000;

    // Decoded form of one code. The pipeline's second stage computes
    // base + (offset << shift). When special is set, base alone is the result.
    typedef struct packed {
        logic [2:0] seg;
        val16_t     offset;
        logic [3:0] shift;
        val16_t     base;
        logic       special;
    } seg_dec_t;

    // Segment index of a code. The segment bases rise monotonically, so the
    // last base that the code reaches gives the segment.
    function automatic logic [2:0] log_seg(input code8_t c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 1; i < LOG_SEGS; i++) begin
            if (c >= LOG_CODE_BASE[i]) s = i[2:0];
        end
        return s;
    endfunction

endpackage

// File: rtl/int8to16_seg_decode.sv
// -----------------------------------------------------------------------------
// int8to16_seg_decode
//   Combinational decode of an 8-bit activation code into the operands of the
//   final add: {seg, offset, shift, base, special}.
//   "lin": the product code*255 is placed in offset, with base 0 and shift 0.
//   "log": segment lookup from the shared codebook. Codes 254 and 255 are
//          constants and set the special flag.
// Ports
//   i_code  in   8   activation code
//   o_dec   out  seg_dec_t  decoded operands
// -----------------------------------------------------------------------------
module int8to16_seg_decode
    import int_conv_pkg::*;
#(
    parameter string pTYPE_OF_TRANSFOR = "lin"
) (
    input  code8_t   i_code,
    output seg_dec_t o_dec
);

    generate
        if (pTYPE_OF_TRANSFOR == "lin") begin : g_lin
            always_comb begin
                o_dec        = '0;
                o_dec.offset = {8'd0, i_code} * 16'd255;
            end
        end else if (pTYPE_OF_TRANSFOR == "log") begin : g_log
            logic [2:0] w_seg;
            assign w_seg = log_seg(i_code);

            always_comb begin
                o_dec     = '0;
                o_dec.seg = w_seg;
                if (i_code == 8'hFF) begin
                    o_dec.base    = LOG_FULL_SCALE;
                    o_dec.special = 1'b1;
                end else if (i_code == 8'hFE) begin
                    o_dec.base    = LOG_C254_VAL;
                    o_dec.special = 1'b1;
                end else begin
                    o_dec.base   = LOG_VAL_BASE[w_seg];
                    o_dec.shift  = LOG_SHIFT[w_seg];
                    o_dec.offset = {8'd0, i_code - LOG_CODE_BASE[w_seg]};
                end
            end
        end else begin : g_bad
            $error("int8to16_seg_decode: pTYPE_OF_TRANSFOR must be \"lin\" or \"log\"");
            assign o_dec = '0;
        end
    endgenerate

endmodule

// File: rtl/int8to16_stream.sv
// -----------------------------------------------------------------------------
// int8to16_stream
//   Streaming expander from 8-bit activation codes to 16-bit values. It is the
//   inverse of the 16->8 activation compressor.
//   2-stage pipeline with a valid/ready handshake on each side:
//     S1 registers the decoded operands of the code and its last flag.
//     S2 registers odata = base + (offset << shift) and olast.
//   With no stall, ovalid rises 2 cycles after the input is accepted, and the
//   block accepts one code per cycle.
// Ports
//   iclk    in   1        clock (posedge)
//   irst    in   1        synchronous active-high reset
//   ivalid  in   1        input code valid
//   idata   in   8        input code
//   ilast   in   1        last code of a frame (qualified by ivalid)
//   oready  out  1        input accepted this cycle (combinational from iready)
//   ovalid  out  1        output valid
//   odata   out  16       expanded value
//   olast   out  1        frame end, aligned with odata
//   iready  in   1        downstream ready
//   ocount  out  pCNT_W   output handshakes in the current frame, including
//                         the one taking place this cycle
// -----------------------------------------------------------------------------
module int8to16_stream
    import int_conv_pkg::*;
#(
    parameter string pTYPE_OF_TRANSFOR = "lin",
    parameter int    pCNT_W            = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ivalid,
    input  logic [7:0]        idata,
    input  logic              ilast,
    output logic              oready,
    output logic              ovalid,
    output logic [15:0]       odata,
    output logic              olast,
    input  logic              iready,
    output logic [pCNT_W-1:0] ocount
);

    localparam int STAGES = 2;

    // Valid bits of the two pipeline stages. Index = stage number.
    logic [STAGES:1]   r_vld_pipe;
    seg_dec_t          r_s1;
    logic              r_s1_last;
    logic [15:0]       r_odata;
    logic              r_olast;
    logic [pCNT_W-1:0] r_cnt;

    seg_dec_t          w_dec;
    logic              w_s1_en;
    logic              w_s2_en;
    logic              w_out_hs;
    logic [16:0]       w_sum;
    logic [pCNT_W-1:0] w_cnt_inc;
    logic              w_unused_seg;

    int8to16_seg_decode #(
        .pTYPE_OF_TRANSFOR (pTYPE_OF_TRANSFOR)
    ) u_dec (
        .i_code (idata),
        .o_dec  (w_dec)
    );

    // A stage may load when it is empty or when its content moves on in the
    // same cycle. Because of this, a full pipeline still accepts a code every
    // cycle while iready is high.
    assign w_s2_en = !r_vld_pipe[2] || iready;
    assign w_s1_en = !r_vld_pipe[1] || w_s2_en;
    assign oready  = w_s1_en;

    // The sum is 17 bits wide. The codebook never produces a result above
    // 16 bits, so only the low 16 bits are kept.
    assign w_sum = r_s1.special ? {1'b0, r_s1.base}
                                : {1'b0, r_s1.base} + ({1'b0, r_s1.offset} << r_s1.shift);

    // The segment index is carried for debug visibility only.
    assign w_unused_seg = ^r_s1.seg;

    assign w_out_hs  = r_vld_pipe[2] && iready;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + {{(pCNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_s1_last  <= 1'b0;
            r_odata    <= '0;
            r_olast    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_s1_en) begin
                r_vld_pipe[1] <= ivalid;
                r_s1          <= w_dec;
                r_s1_last     <= ilast && ivalid;
            end
            if (w_s2_en) begin
                r_vld_pipe[2] <= r_vld_pipe[1];
                // A bubble does not overwrite the data, so odata keeps its last value.
                if (r_vld_pipe[1]) begin
                    r_odata <= w_sum[15:0];
                    r_olast <= r_s1_last;
                end
            end
            if (w_out_hs) begin
                r_cnt <= r_olast ? '0 : w_cnt_inc;
            end
        end
    end

    assign ovalid = r_vld_pipe[2];
    assign odata  = r_odata;
    assign olast  = r_olast;
    // During a handshake, the count already includes the sample being taken.
    assign ocount = w_out_hs ? w_cnt_inc : r_cnt;

endmodule

// File: tb/tb_int8to16_stream.sv
module tb_int8to16_stream;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic [7:0]  idata;
    logic        ilast;
    logic        iready;

    logic        oready_log, ovalid_log, olast_log;
    logic [15:0] odata_log, ocount_log;
    logic        oready_lin, ovalid_lin, olast_lin;
    logic [15:0] odata_lin;
    logic [2:0]  ocount_lin;

    always #5 iclk = ~iclk;

    int8to16_stream #(.pTYPE_OF_TRANSFOR("log"), .pCNT_W(16)) u_dut_log (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata), .ilast(ilast),
        .oready(oready_log), .ovalid(ovalid_log), .odata(odata_log), .olast(olast_log),
        .iready(iready), .ocount(ocount_log)
    );

    // A narrow counter lets the bench reach saturation.
    int8to16_stream #(.pTYPE_OF_TRANSFOR("lin"), .pCNT_W(3)) u_dut_lin (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata), .ilast(ilast),
        .oready(oready_lin), .ovalid(ovalid_lin), .odata(odata_lin), .olast(olast_lin),
        .iready(iready), .ocount(ocount_lin)
    );

    typedef struct {
        int vlog;
        int vlin;
        bit last;
        int cyc;
    } ent_t;

    ent_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cnt_log = 0;
    int          cnt_lin = 0;
    bit          took;
    bit          chk_rst;
    bit          hold;
    logic [15:0] hold_d;
    logic        hold_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_log(input int c);
        if (c < 128) return c;
        if (c < 192) return 128  + (c - 128) * 2;
        if (c < 224) return 256  + (c - 192) * 8;
        if (c < 240) return 512  + (c - 224) * 32;
        if (c < 248) return 1024 + (c - 240) * 128;
        if (c < 252) return 2048 + (c - 248) * 512;
        if (c < 254) return 4096 + (c - 252) * 2048;
        if (c == 254) return 32768;
        return 65535;
    endfunction

    task automatic drv(input bit v, input int d, input bit l, input bit r);
        ivalid = v;
        idata  = 8'(d);
        ilast  = l;
        iready = r;
    endtask

    // One clock cycle. Outputs are checked at the negedge against the model,
    // and then the model is updated with this cycle's handshakes.
    // The pipeline holds at most 2 codes. The oldest code is visible at the
    // output from 2 cycles after it was accepted until it is taken.
    task automatic tick();
        bit   exp_v, m_rdy;
        int   ec_log, ec_lin;
        ent_t e;
        @(negedge iclk);
        cyc++;
        took = 0;
        if (!irst) begin
            if (chk_rst) begin
                chk("rst_odata_log", odata_log, 0);
                chk("rst_odata_lin", odata_lin, 0);
                chk("rst_olast_log", olast_log, 0);
                chk("rst_ocount_log", ocount_log, 0);
                chk("rst_ocount_lin", ocount_lin, 0);
                chk_rst = 0;
            end
            m_rdy = iready || (q.size() < 2);
            exp_v = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            chk("oready_log", oready_log, m_rdy);
            chk("oready_lin", oready_lin, m_rdy);
            chk("ovalid_log", ovalid_log, exp_v);
            chk("ovalid_lin", ovalid_lin, exp_v);
            if (hold) begin
                chk("hold_odata", odata_log, hold_d);
                chk("hold_olast", olast_log, hold_l);
            end
            if (exp_v && iready) begin
                e = q.pop_front();
                chk("odata_log", odata_log, e.vlog);
                chk("odata_lin", odata_lin, e.vlin);
                chk("olast_log", olast_log, e.last);
                chk("olast_lin", olast_lin, e.last);
                ec_log = (cnt_log == 65535) ? cnt_log : cnt_log + 1;
                ec_lin = (cnt_lin == 7) ? cnt_lin : cnt_lin + 1;
                chk("ocount_log", ocount_log, ec_log);
                chk("ocount_lin", ocount_lin, ec_lin);
                cnt_log = e.last ? 0 : ec_log;
                cnt_lin = e.last ? 0 : ec_lin;
            end else begin
                chk("ocount_idle_log", ocount_log, cnt_log);
                chk("ocount_idle_lin", ocount_lin, cnt_lin);
            end
            hold   = exp_v && !iready;
            hold_d = odata_log;
            hold_l = olast_log;
            if (ivalid && m_rdy) begin
                q.push_back('{ref_log(int'(idata)), int'(idata) * 255, ilast, cyc});
                took = 1;
            end
        end
        @(posedge iclk);
        if (irst) begin
            q.delete();
            cnt_log = 0;
            cnt_lin = 0;
            hold    = 0;
        end
        #1;
    endtask

    task automatic send_list(input int codes[$], input int last_idx);
        for (int i = 0; i < codes.size(); i++) begin
            drv(1, codes[i], i == last_idx, 1);
            tick();
        end
    endtask

    task automatic drain(input int n);
        drv(0, 0, 0, 1);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int codes[$];
        int k, c;

        irst = 1;
        drv(0, 0, 0, 1);
        tick();
        tick();
        irst = 0;
        chk_rst = 1;
        drain(1);

        // Log codebook with no stall, including the segment edges and the
        // constant codes.
        codes = '{8'h05, 8'h80, 8'hC1, 8'hFB, 8'hFD};
        send_list(codes, -1);
        codes = '{8'hFE, 8'hFF, 8'h7F, 8'hF0, 8'hBF, 8'hDF, 8'hEF, 8'hF7};
        send_list(codes, 7);
        drain(3);
        // Values for the linear codebook.
        codes = '{8'h00, 8'h02, 8'hFF};
        send_list(codes, 2);
        drain(3);

        // Backpressure: iready low for 5 cycles in the middle of 8 codes.
        k = 0;
        c = 0;
        while (k < 8 && c < 100) begin
            drv(1, 8'h10 * k + 3, 0, !(c >= 3 && c < 8));
            tick();
            if (took) k++;
            c++;
        end
        chk("bp_all_sent", k, 8);
        drain(4);

        // Frames of 3 and 2 codes.
        codes = '{8'h01, 8'h02, 8'h03};
        send_list(codes, 2);
        codes = '{8'h04, 8'h05};
        send_list(codes, 1);
        drain(3);
        // A long frame saturates the 3-bit counter.
        codes = '{};
        for (int i = 0; i < 11; i++) codes.push_back(i + 20);
        send_list(codes, 10);
        drain(3);

        // ilast without ivalid is ignored.
        drv(0, 0, 1, 1);
        tick();
        drain(2);

        // Reset with 4 samples already counted and 2 codes in flight.
        codes = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_list(codes, -1);
        drain(3);
        chk("pre_rst_count", ocount_log, 4);
        drv(1, 8'hAA, 0, 0);
        tick();
        drv(1, 8'hBB, 0, 0);
        tick();
        chk("pre_rst_inflight", q.size(), 2);
        irst = 1;
        drv(0, 0, 0, 0);
        tick();
        irst = 0;
        chk_rst = 1;
        drain(4);

        // Randomized traffic, with an occasional reset.
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
            irst = ($urandom_range(0, 199) == 0);
            tick();
            irst = 0;
        end
        drain(5);
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
